// File: rtl/memory_stage.sv
// ============================================================================
//  Module      : memory_stage
//  Description : Y86-64 memory stage. Decodes the data-memory access of one
//                instruction per handshake, drives a req/ack RAM port and
//                returns valM plus an address/RAM error flag.
//                Optional macro MEM_TIMEOUT_EN: abort a request that sees no
//                ack within TIMEOUT_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_stage #(
    parameter int MEM_BYTES      = 8192,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [3:0]  icode_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valA_i,
    input  logic [63:0] valP_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [63:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        done_o,
    output logic [63:0] valM_o,
    output logic        dmem_error_o
);

    localparam logic [63:0] c_max_addr = 64'(MEM_BYTES - 8);

    localparam logic [3:0] c_icode_rmmovq = 4'h4;
    localparam logic [3:0] c_icode_mrmovq = 4'h5;
    localparam logic [3:0] c_icode_call   = 4'h8;
    localparam logic [3:0] c_icode_ret    = 4'h9;
    localparam logic [3:0] c_icode_pushq  = 4'hA;
    localparam logic [3:0] c_icode_popq   = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Parameter sanity: an 8-byte access must fit and the timeout must be nonzero.
    generate
        if (MEM_BYTES < 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("memory_stage: MEM_BYTES must be >= 8 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    state_t      r_state;
    logic        r_ready;
    logic        r_req;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_done;
    logic [63:0] r_valm;
    logic        r_err;

    logic        w_is_mem;
    logic        w_we;
    logic [63:0] w_addr;
    logic [63:0] w_wdata;
    logic        w_in_range;
    logic        w_accept;

`ifdef MEM_TIMEOUT_EN
    localparam int c_cnt_w = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    logic [c_cnt_w-1:0] r_cnt;
`endif

    // Access decode: stack ops pop/return through valA, everything else uses valE.
    always_comb begin
        w_is_mem = 1'b0;
        w_we     = 1'b0;
        w_addr   = valE_i;
        w_wdata  = valA_i;
        case (icode_i)
            c_icode_rmmovq, c_icode_pushq: begin
                w_is_mem = 1'b1;
                w_we     = 1'b1;
            end
            c_icode_call: begin
                w_is_mem = 1'b1;
                w_we     = 1'b1;
                w_wdata  = valP_i;
            end
            c_icode_mrmovq: begin
                w_is_mem = 1'b1;
            end
            c_icode_popq, c_icode_ret: begin
                w_is_mem = 1'b1;
                w_addr   = valA_i;
            end
            default: begin
                w_is_mem = 1'b0;
            end
        endcase
    end

    // Single unsigned compare: anything near 2^64 is simply above the limit.
    assign w_in_range = (w_addr <= c_max_addr);
    assign w_accept   = valid_i && r_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_done  <= 1'b0;
            r_valm  <= 64'd0;
            r_err   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we    <= w_we;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_ready <= 1'b0;
                        if (w_is_mem && w_in_range) begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end else begin
                            // No-access or out-of-range: finish without touching RAM.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_valm  <= 64'd0;
                            r_err   <= w_is_mem;
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (mem_ack_i) begin
                        r_state <= ST_DONE;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_valm  <= r_we ? 64'd0 : mem_rdata_i;
                        r_err   <= mem_err_i;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_cnt >= c_cnt_last) begin
                        r_state <= ST_DONE;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_valm  <= 64'd0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o      = r_ready;
    assign mem_req_o    = r_req;
    assign mem_we_o     = r_we;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;
    assign done_o       = r_done;
    assign valM_o       = r_valm;
    assign dmem_error_o = r_err;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
//  Module      : tb_memory_stage
//  Description : Directed self-checking bench for memory_stage with a result
//                scoreboard filled at issue and drained on done_o.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_stage;

    localparam int MEM_BYTES = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [63:0] val_p;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic        done;
    logic [63:0] val_m;
    logic        dmem_error;

    typedef struct packed {
        logic [63:0] valm;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    memory_stage #(.MEM_BYTES(MEM_BYTES), .TIMEOUT_CYCLES(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid),
        .ready_o      (ready),
        .icode_i      (icode),
        .valE_i       (val_e),
        .valA_i       (val_a),
        .valP_i       (val_p),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata),
        .mem_err_i    (mem_err),
        .done_o       (done),
        .valM_o       (val_m),
        .dmem_error_o (dmem_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a single accept edge; leaves time at cycle T+1.
    task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                         input logic [63:0] p, input bit push, input logic [63:0] exp_valm,
                         input logic exp_err);
        chk("ready_before_issue", ready, 1);
        icode = ic;
        val_e = e;
        val_a = a;
        val_p = p;
        valid = 1'b1;
        if (push) sb.push_back('{valm: exp_valm, err: exp_err});
        tick();
        valid = 1'b0;
        icode = 4'h0;
        val_e = 64'hBAD0_BAD0_BAD0_BAD0;
        val_a = 64'hBAD1_BAD1_BAD1_BAD1;
        val_p = 64'hBAD2_BAD2_BAD2_BAD2;
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_req_low"}, mem_req, 0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valm"}, val_m, e.valm);
            chk({tag, "_err"}, dmem_error, e.err);
        end
        tick();
        chk({tag, "_done_once"}, done, 0);
        chk({tag, "_ready_after"}, ready, 1);
        chk({tag, "_valm_hold"}, val_m, e.valm);
    endtask

    // Hold the request through `waits` idle cycles, ack on the next, and check
    // that the request fields stay put. Junk valid traffic must be ignored.
    task automatic mem_op(input string tag, input logic exp_we, input logic [63:0] exp_addr,
                          input bit chk_wdata, input logic [63:0] exp_wdata, input int waits,
                          input logic [63:0] rdata, input logic err);
        valid = 1'b1;
        icode = 4'h6;
        for (int i = 0; i <= waits; i++) begin
            chk({tag, "_req"}, mem_req, 1);
            chk({tag, "_we"}, mem_we, exp_we);
            chk({tag, "_addr"}, mem_addr, exp_addr);
            if (chk_wdata) chk({tag, "_wdata"}, mem_wdata, exp_wdata);
            chk({tag, "_no_early_done"}, done, 0);
            chk({tag, "_ready_low"}, ready, 0);
            if (i == waits) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                mem_err   = err;
            end
            tick();
        end
        valid     = 1'b0;
        mem_ack   = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        check_done(tag);
    endtask

    initial begin
        rst       = 1'b1;
        valid     = 1'b0;
        icode     = 4'h0;
        val_e     = 64'd0;
        val_a     = 64'd0;
        val_p     = 64'd0;
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_0000_FFFF_0000;
        mem_err   = 1'b1;

        // Reset with a stray ack active
        tick();
        tick();
        chk("rst_ready", ready, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_valm", val_m, 0);
        chk("rst_err", dmem_error, 0);
        rst     = 1'b0;
        mem_ack = 1'b0;
        mem_err = 1'b0;
        tick();
        chk("post_rst_ready", ready, 1);
        chk("post_rst_done", done, 0);

        // addq: no access, one-cycle latency
        issue(4'h6, 64'd300, 64'd7, 64'd9, 1, 64'd0, 1'b0);
        check_done("addq");

        // rmmovq with three wait cycles
        issue(4'h4, 64'h100, 64'hDEAD, 64'h11, 1, 64'd0, 1'b0);
        mem_op("rmmovq", 1'b1, 64'h100, 1, 64'hDEAD, 3, 64'h5555, 1'b0);

        // popq reads through valA, zero-wait RAM
        issue(4'hB, 64'h777, 64'h1F8, 64'h22, 1, 64'h1234, 1'b0);
        mem_op("popq", 1'b0, 64'h1F8, 0, 64'd0, 0, 64'h1234, 1'b0);

        // call writes valP
        issue(4'h8, 64'h1F0, 64'h5, 64'h40, 1, 64'd0, 1'b0);
        mem_op("call", 1'b1, 64'h1F0, 1, 64'h40, 1, 64'h9999, 1'b0);

        // ret reads through valA
        issue(4'h9, 64'h0, 64'h80, 64'h33, 1, 64'hABCD, 1'b0);
        mem_op("ret", 1'b0, 64'h80, 0, 64'd0, 2, 64'hABCD, 1'b0);

        // pushq writes valA at valE
        issue(4'hA, 64'h1E8, 64'h4242, 64'h44, 1, 64'd0, 1'b0);
        mem_op("pushq", 1'b1, 64'h1E8, 1, 64'h4242, 0, 64'h1, 1'b0);

        // mrmovq at the last legal address
        issue(4'h5, 64'(MEM_BYTES - 8), 64'h0, 64'h0, 1, 64'h99, 1'b0);
        mem_op("mrmovq_edge", 1'b0, 64'(MEM_BYTES - 8), 0, 64'd0, 0, 64'h99, 1'b0);

        // Out-of-range addresses: no request, error result
        issue(4'h5, 64'(MEM_BYTES - 7), 64'h0, 64'h0, 1, 64'd0, 1'b1);
        chk("oor1_no_req", mem_req, 0);
        check_done("oor1");
        issue(4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 1, 64'd0, 1'b1);
        chk("oor_wrap_no_req", mem_req, 0);
        check_done("oor_wrap");
        issue(4'hB, 64'h0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 1, 64'd0, 1'b1);
        chk("oor_pop_no_req", mem_req, 0);
        check_done("oor_pop");

        // RAM fault on a write
        issue(4'h4, 64'h200, 64'h77, 64'h0, 1, 64'd0, 1'b1);
        mem_op("ram_err", 1'b1, 64'h200, 1, 64'h77, 1, 64'h0, 1'b1);

        // Invalid icode: no access even with a legal address
        issue(4'hF, 64'h100, 64'h100, 64'h0, 1, 64'd0, 1'b0);
        chk("invalid_no_req", mem_req, 0);
        check_done("invalid");

        // Ack while idle is ignored
        mem_ack   = 1'b1;
        mem_rdata = 64'h6666;
        tick();
        chk("idle_ack_done", done, 0);
        tick();
        chk("idle_ack_done2", done, 0);
        chk("idle_ack_valm", val_m, 0);
        mem_ack = 1'b0;

        // Reset during REQ, then a late ack
        issue(4'h5, 64'h300, 64'h0, 64'h0, 0, 64'd0, 1'b0);
        chk("rst_req_pending", mem_req, 1);
        tick();
        chk("rst_req_pending2", mem_req, 1);
        rst = 1'b1;
        tick();
        chk("rst_req_dropped", mem_req, 0);
        chk("rst_req_ready", ready, 0);
        chk("rst_req_addr", mem_addr, 0);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 64'h7777;
        tick();
        chk("late_ack_done", done, 0);
        chk("late_ack_req", mem_req, 0);
        chk("late_ack_ready", ready, 1);
        tick();
        chk("late_ack_done2", done, 0);
        chk("late_ack_valm", val_m, 0);
        mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after 16 REQ cycles
        issue(4'h5, 64'h300, 64'h0, 64'h0, 1, 64'd0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk("tmo_req", mem_req, 1);
            chk("tmo_no_done", done, 0);
            tick();
        end
        check_done("timeout");
`else
        // Without the timeout, REQ waits indefinitely
        issue(4'h5, 64'h300, 64'h0, 64'h0, 0, 64'd0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            chk("wait_req", mem_req, 1);
            chk("wait_no_done", done, 0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("wait_cleared", mem_req, 0);
`endif

        chk("sb_drained", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
